// File: rtl/bp_cce_hybrid_pending_multi.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_hybrid_pending_multi (+ _fifo helper)
// Brief    : Multi-queue pending stage between LCE requests and the CCE
//            pipeline. Optional fairness limit: BP_CCE_HYBRID_PENDING_FAIRNESS_EN
// Revision : 1.0  initial release
// ============================================================================

module bp_cce_hybrid_pending_multi_fifo
  #(parameter int width_p = 8
   ,parameter int els_p   = 2
   )
  (input  logic               clk_i
  ,input  logic               reset_i
  ,input  logic               enq_i
  ,input  logic [width_p-1:0] data_i
  ,input  logic               deq_i
  ,output logic               v_o
  ,output logic               full_o
  ,output logic [width_p-1:0] data_o
  );

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  mem_q [els_p];
   logic [ptr_w_lp-1:0] wr_q, rd_q;
   logic [cnt_w_lp-1:0] cnt_q;
   logic                enq_ok, deq_ok;

   function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign v_o    = (cnt_q != '0);
   assign full_o = (cnt_q == cnt_w_lp'(els_p));
   assign data_o = mem_q[rd_q];
   assign enq_ok = enq_i & ~full_o;
   assign deq_ok = deq_i & v_o;

   always_ff @(posedge clk_i) begin
      if (enq_ok) mem_q[wr_q] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (enq_ok) wr_q <= bump(wr_q);
         if (deq_ok) rd_q <= bump(rd_q);
         cnt_q <= cnt_q + cnt_w_lp'(enq_ok) - cnt_w_lp'(deq_ok);
      end
   end

endmodule

module bp_cce_hybrid_pending_multi
  #(parameter int paddr_width_p     = 40
   ,parameter int lce_id_width_p    = 4
   ,parameter int cce_id_width_p    = 4
   ,parameter int lce_assoc_p       = 8
   ,parameter int cce_block_width_p = 512
   ,parameter int lce_data_width_p  = 64
   ,parameter int num_queues_p      = 4
   ,parameter int header_els_p      = 2
   ,parameter int data_els_p        = 2
   ,parameter int max_streak_p      = 4
   ,localparam int lce_req_msg_header_width_lp =
      paddr_width_p + lce_id_width_p + cce_id_width_p + $clog2(lce_assoc_p) + 8
   )
  (input  logic                                       clk_i
  ,input  logic                                       reset_i
   // new LCE request; address occupies the low paddr_width_p header bits
  ,input  logic [lce_req_msg_header_width_lp-1:0]     lce_req_header_i
  ,input  logic                                       lce_req_header_v_i
  ,output logic                                       lce_req_header_ready_and_o
  ,input  logic                                       lce_req_has_data_i
  ,input  logic [lce_data_width_p-1:0]                lce_req_data_i
  ,input  logic                                       lce_req_data_v_i
  ,output logic                                       lce_req_data_ready_and_o
  ,input  logic                                       lce_req_last_i
   // request to the CCE pipeline
  ,output logic [lce_req_msg_header_width_lp-1:0]     lce_req_header_o
  ,output logic                                       lce_req_header_v_o
  ,input  logic                                       lce_req_header_ready_and_i
  ,output logic                                       lce_req_has_data_o
  ,output logic [lce_data_width_p-1:0]                lce_req_data_o
  ,output logic                                       lce_req_data_v_o
  ,input  logic                                       lce_req_data_ready_and_i
  ,output logic                                       lce_req_last_o
   // pending-bit lookup
  ,output logic [(num_queues_p+1)*paddr_width_p-1:0]  pending_r_addr_o
  ,input  logic [num_queues_p:0]                      pending_r_i
   // external pending write request
  ,input  logic                                       pending_w_v_i
  ,output logic                                       pending_w_yumi_o
  ,input  logic [paddr_width_p-1:0]                   pending_w_addr_i
  ,input  logic                                       pending_w_addr_bypass_hash_i
  ,input  logic                                       pending_up_i
  ,input  logic                                       pending_down_i
  ,input  logic                                       pending_clear_i
   // merged pending write
  ,output logic                                       pending_w_v_o
  ,output logic [paddr_width_p-1:0]                   pending_w_addr_o
  ,output logic                                       pending_w_addr_bypass_hash_o
  ,output logic                                       pending_up_o
  ,output logic                                       pending_down_o
  ,output logic                                       pending_clear_o
  ,output logic                                       empty_o
  );

   localparam int hdr_w_lp          = lce_req_msg_header_width_lp;
   localparam int lg_nq_lp          = (num_queues_p > 1) ? $clog2(num_queues_p) : 1;
   localparam int lg_block_bytes_lp = $clog2(cce_block_width_p / 8);

   if ((num_queues_p < 1) || ((num_queues_p & (num_queues_p - 1)) != 0)
       || (header_els_p < 1) || (data_els_p < 1) || (max_streak_p < 1)) begin : g_cfg_check
      $error("bp_cce_hybrid_pending_multi: illegal parameter set");
   end

   typedef enum logic [1:0] {
      e_ready           = 2'd0,
      e_data_to_out     = 2'd1,
      e_data_to_pending = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [lg_nq_lp-1:0]    rr_q, rr_d, src_q, src_d;
   logic                   src_in_q, src_in_d;

   logic [num_queues_p-1:0] hq_v, hq_full, hq_enq, hq_deq;
   logic [num_queues_p-1:0] dq_v, dq_full, dq_enq, dq_deq;
   logic [hdr_w_lp:0]         hq_head [num_queues_p];  // {has_data, header}
   logic [lce_data_width_p:0] dq_head [num_queues_p];  // {last, data}

   logic [paddr_width_p-1:0] in_addr;
   logic [lg_nq_lp-1:0]      in_qidx, q_grant;
   logic [num_queues_p-1:0]  unblk, nonempty;
   logic                     q_grant_v, new_unblk, favor_new, use_queue;
   logic                     hdr_fire, queue_fire, new_fire;

   assign in_addr = lce_req_header_i[paddr_width_p-1:0];
   assign pending_r_addr_o[0 +: paddr_width_p] = in_addr;
   assign empty_o = reset_i | ~|(hq_v | dq_v);

   for (genvar q = 0; q < num_queues_p; q++) begin : g_queue
      bp_cce_hybrid_pending_multi_fifo
        #(.width_p(hdr_w_lp + 1), .els_p(header_els_p))
        hdr_fifo
         (.clk_i(clk_i), .reset_i(reset_i)
         ,.enq_i(hq_enq[q]), .data_i({lce_req_has_data_i, lce_req_header_i})
         ,.deq_i(hq_deq[q]), .v_o(hq_v[q]), .full_o(hq_full[q]), .data_o(hq_head[q]));

      bp_cce_hybrid_pending_multi_fifo
        #(.width_p(lce_data_width_p + 1), .els_p(data_els_p))
        data_fifo
         (.clk_i(clk_i), .reset_i(reset_i)
         ,.enq_i(dq_enq[q]), .data_i({lce_req_last_i, lce_req_data_i})
         ,.deq_i(dq_deq[q]), .v_o(dq_v[q]), .full_o(dq_full[q]), .data_o(dq_head[q]));

      assign pending_r_addr_o[(q+1)*paddr_width_p +: paddr_width_p] = hq_head[q][paddr_width_p-1:0];
   end

   // Lookup decode and round-robin pick among unblocked queue heads
   always_comb begin
      int k;
      k         = 0;
      in_qidx   = '0;
      q_grant   = '0;
      q_grant_v = 1'b0;
      if (num_queues_p > 1) in_qidx = in_addr[lg_block_bytes_lp +: lg_nq_lp];
      nonempty  = hq_v | dq_v;
      for (int q = 0; q < num_queues_p; q++) begin
         unblk[q] = hq_v[q] & ~pending_r_i[q+1];
      end
      for (int i = 0; i < num_queues_p; i++) begin
         k = (int'(rr_q) + i) % num_queues_p;
         if (!q_grant_v && unblk[k]) begin
            q_grant_v = 1'b1;
            q_grant   = lg_nq_lp'(k);
         end
      end
      new_unblk = lce_req_header_v_i & ~pending_r_i[0] & ~nonempty[in_qidx];
   end

`ifdef BP_CCE_HYBRID_PENDING_FAIRNESS_EN
   localparam int streak_w_lp = $clog2(max_streak_p + 1);
   logic [streak_w_lp-1:0] streak_q, streak_d;

   assign favor_new = new_unblk && (streak_q >= streak_w_lp'(max_streak_p));

   always_comb begin
      streak_d = streak_q;
      if (new_fire)
         streak_d = '0;
      else if (queue_fire && (streak_q != streak_w_lp'(max_streak_p)))
         streak_d = streak_q + streak_w_lp'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) streak_q <= '0;
      else         streak_q <= streak_d;
   end
`else
   assign favor_new = 1'b0;
`endif

   assign use_queue = q_grant_v & ~favor_new;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      src_d    = src_q;
      src_in_d = src_in_q;
      hq_enq   = '0;
      hq_deq   = '0;
      dq_enq   = '0;
      dq_deq   = '0;
      queue_fire = 1'b0;
      new_fire   = 1'b0;
      lce_req_header_o           = '0;
      lce_req_header_v_o         = 1'b0;
      lce_req_has_data_o         = 1'b0;
      lce_req_header_ready_and_o = 1'b0;
      lce_req_data_o             = '0;
      lce_req_data_v_o           = 1'b0;
      lce_req_last_o             = 1'b0;
      lce_req_data_ready_and_o   = 1'b0;

      case (state_q)
         e_ready: begin
            if (use_queue) begin
               lce_req_header_v_o = 1'b1;
               {lce_req_has_data_o, lce_req_header_o} = hq_head[q_grant];
               if (lce_req_header_ready_and_i) begin
                  queue_fire       = 1'b1;
                  hq_deq[q_grant]  = 1'b1;
                  rr_d = (q_grant == lg_nq_lp'(num_queues_p - 1)) ? '0 : q_grant + lg_nq_lp'(1);
                  src_d    = q_grant;
                  src_in_d = 1'b0;
                  if (hq_head[q_grant][hdr_w_lp]) state_d = e_data_to_out;
               end
            end else if (new_unblk) begin
               lce_req_header_v_o         = 1'b1;
               lce_req_header_o           = lce_req_header_i;
               lce_req_has_data_o         = lce_req_has_data_i;
               lce_req_header_ready_and_o = lce_req_header_ready_and_i;
               if (lce_req_header_ready_and_i) begin
                  new_fire = 1'b1;
                  src_in_d = 1'b1;
                  if (lce_req_has_data_i) state_d = e_data_to_out;
               end
            end else if (lce_req_header_v_i) begin
               lce_req_header_ready_and_o = ~hq_full[in_qidx];
               if (!hq_full[in_qidx]) begin
                  hq_enq[in_qidx] = 1'b1;
                  src_d           = in_qidx;
                  if (lce_req_has_data_i) state_d = e_data_to_pending;
               end
            end
         end
         e_data_to_out: begin
            if (src_in_q) begin
               lce_req_data_v_o         = lce_req_data_v_i;
               lce_req_data_o           = lce_req_data_i;
               lce_req_last_o           = lce_req_last_i;
               lce_req_data_ready_and_o = lce_req_data_ready_and_i;
            end else begin
               lce_req_data_v_o = dq_v[src_q];
               {lce_req_last_o, lce_req_data_o} = dq_head[src_q];
               dq_deq[src_q] = dq_v[src_q] & lce_req_data_ready_and_i;
            end
            if (lce_req_data_v_o && lce_req_data_ready_and_i && lce_req_last_o) state_d = e_ready;
         end
         e_data_to_pending: begin
            lce_req_data_ready_and_o = ~dq_full[src_q];
            if (lce_req_data_v_i && !dq_full[src_q]) begin
               dq_enq[src_q] = 1'b1;
               if (lce_req_last_i) state_d = e_ready;
            end
         end
         default: state_d = e_ready;
      endcase

      if (reset_i) begin
         hq_enq = '0;
         hq_deq = '0;
         dq_enq = '0;
         dq_deq = '0;
         queue_fire = 1'b0;
         new_fire   = 1'b0;
         lce_req_header_v_o         = 1'b0;
         lce_req_header_ready_and_o = 1'b0;
         lce_req_data_v_o           = 1'b0;
         lce_req_data_ready_and_o   = 1'b0;
      end

      // A header leaving this cycle claims the pending table; external write waits
      hdr_fire = lce_req_header_v_o & lce_req_header_ready_and_i;
      if (hdr_fire) begin
         pending_w_v_o                = 1'b1;
         pending_w_addr_o             = lce_req_header_o[paddr_width_p-1:0];
         pending_w_addr_bypass_hash_o = 1'b0;
         pending_up_o                 = 1'b1;
         pending_down_o               = 1'b0;
         pending_clear_o              = 1'b0;
         pending_w_yumi_o             = 1'b0;
      end else begin
         pending_w_v_o                = pending_w_v_i & ~reset_i;
         pending_w_addr_o             = pending_w_addr_i;
         pending_w_addr_bypass_hash_o = pending_w_addr_bypass_hash_i;
         pending_up_o                 = pending_up_i;
         pending_down_o               = pending_down_i;
         pending_clear_o              = pending_clear_i;
         pending_w_yumi_o             = pending_w_v_i & ~reset_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= e_ready;
         rr_q     <= '0;
         src_q    <= '0;
         src_in_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         src_q    <= src_d;
         src_in_q <= src_in_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_hybrid_pending_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cce_hybrid_pending_multi
// Brief    : Self-checking bench: combinational vector table plus scoreboarded
//            sequences for queueing, round-robin drain and stall cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_cce_hybrid_pending_multi;

   localparam int PA = 40;
   localparam int NQ = 4;
   localparam int HW = 59;
   localparam int DW = 64;
`ifdef BP_CCE_HYBRID_PENDING_FAIRNESS_EN
   localparam int MS = 2;
`else
   localparam int MS = 4;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [HW-1:0] hdr_i, hdr_o;
   logic hv_i, hrdy_o, hd_i, hv_o, hrdy_i, hd_o;
   logic [DW-1:0] d_i, d_o;
   logic dv_i, drdy_o, last_i, dv_o, drdy_i, last_o;
   logic [(NQ+1)*PA-1:0] r_addr;
   logic [NQ:0] pend;
   logic ew_v, ew_byp, ew_up, ew_down, ew_clr, yumi_o;
   logic [PA-1:0] ew_addr, w_addr_o;
   logic w_v_o, w_byp_o, up_o, down_o, clr_o, empty_o;

   bp_cce_hybrid_pending_multi #(
      .paddr_width_p(PA), .lce_id_width_p(4), .cce_id_width_p(4), .lce_assoc_p(8),
      .cce_block_width_p(512), .lce_data_width_p(DW), .num_queues_p(NQ),
      .header_els_p(2), .data_els_p(4), .max_streak_p(MS)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .lce_req_header_i(hdr_i), .lce_req_header_v_i(hv_i), .lce_req_header_ready_and_o(hrdy_o),
      .lce_req_has_data_i(hd_i), .lce_req_data_i(d_i), .lce_req_data_v_i(dv_i),
      .lce_req_data_ready_and_o(drdy_o), .lce_req_last_i(last_i),
      .lce_req_header_o(hdr_o), .lce_req_header_v_o(hv_o), .lce_req_header_ready_and_i(hrdy_i),
      .lce_req_has_data_o(hd_o), .lce_req_data_o(d_o), .lce_req_data_v_o(dv_o),
      .lce_req_data_ready_and_i(drdy_i), .lce_req_last_o(last_o),
      .pending_r_addr_o(r_addr), .pending_r_i(pend),
      .pending_w_v_i(ew_v), .pending_w_yumi_o(yumi_o), .pending_w_addr_i(ew_addr),
      .pending_w_addr_bypass_hash_i(ew_byp), .pending_up_i(ew_up), .pending_down_i(ew_down),
      .pending_clear_i(ew_clr),
      .pending_w_v_o(w_v_o), .pending_w_addr_o(w_addr_o), .pending_w_addr_bypass_hash_o(w_byp_o),
      .pending_up_o(up_o), .pending_down_o(down_o), .pending_clear_o(clr_o),
      .empty_o(empty_o)
   );

   int total = 0;
   int bad   = 0;
   logic [HW:0] exp_hdr [$];
   logic [DW:0] exp_dat [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] dat(input logic [18:0] tag, input int b);
      return {13'd0, tag, 32'(b)};
   endfunction

   // Scoreboard: every output handshake must match the oldest expected item
   always @(negedge clk) begin
      if (!reset) begin
         if (hv_o && hrdy_i) begin
            if (exp_hdr.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected header: got %h expected none", hdr_o);
            end else begin
               logic [HW:0] e;
               e = exp_hdr.pop_front();
               chk("out header", {hd_o, hdr_o}, e);
               chk("send pending write", {w_v_o, up_o, down_o, clr_o, w_byp_o, yumi_o, w_addr_o},
                   {6'b110000, e[PA-1:0]});
            end
         end
         if (dv_o && drdy_i) begin
            if (exp_dat.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected beat: got %h expected none", d_o);
            end else begin
               logic [DW:0] e;
               e = exp_dat.pop_front();
               chk("out beat", {last_o, d_o}, e);
            end
         end
      end
   end

   task automatic exp_req(input logic [PA-1:0] a, input logic [18:0] tag, input int nb);
      exp_hdr.push_back({(nb > 0), tag, a});
      for (int b = 0; b < nb; b++) exp_dat.push_back({(b == nb - 1), dat(tag, b)});
   endtask

   task automatic wait_in(input bit data_ch);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         if (data_ch ? (drdy_o && dv_i) : (hrdy_o && hv_i)) ok = 1'b1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL input handshake timeout: got ready=0 expected ready=1");
      end
      @(posedge clk); #1;
   endtask

   task automatic send_req(input logic [PA-1:0] a, input logic [18:0] tag, input int nb);
      @(posedge clk); #1;
      hdr_i = {tag, a}; hd_i = (nb > 0); hv_i = 1'b1;
      wait_in(1'b0);
      hv_i = 1'b0;
      for (int b = 0; b < nb; b++) begin
         d_i = dat(tag, b); last_i = (b == nb - 1); dv_i = 1'b1;
         wait_in(1'b1);
         dv_i = 1'b0; last_i = 1'b0;
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk); #1;
         if (exp_hdr.size() == 0 && exp_dat.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL drain timeout: got %0d items left expected 0", exp_hdr.size() + exp_dat.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic set_pend(input logic [NQ:0] p);
      @(posedge clk); #1;
      pend = p;
   endtask

   typedef struct packed {
      logic          in_v;
      logic [PA-1:0] addr;
      logic          pend0;
      logic          ordy;
      logic          ew_v;
      logic [PA-1:0] ew_addr;
      logic          ew_down;
      logic          e_rdy;
      logic          e_outv;
      logic          e_wv;
      logic [PA-1:0] e_waddr;
      logic          e_up;
      logic          e_down;
      logic          e_yumi;
   } vec_t;
   vec_t vt [6];

   initial begin
      vt[0] = '{1'b1, 40'h1000, 1'b0, 1'b1, 1'b0, 40'h0,    1'b0, 1'b1, 1'b1, 1'b1, 40'h1000, 1'b1, 1'b0, 1'b0};
      vt[1] = '{1'b1, 40'h1000, 1'b0, 1'b1, 1'b1, 40'h2000, 1'b1, 1'b1, 1'b1, 1'b1, 40'h1000, 1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 40'h1000, 1'b0, 1'b1, 1'b1, 40'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 40'h2000, 1'b0, 1'b1, 1'b1};
      vt[3] = '{1'b1, 40'h1000, 1'b1, 1'b1, 1'b0, 40'h0,    1'b0, 1'b1, 1'b0, 1'b0, 40'h0,    1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b1, 40'h1000, 1'b0, 1'b0, 1'b1, 40'h2000, 1'b1, 1'b0, 1'b1, 1'b1, 40'h2000, 1'b0, 1'b1, 1'b1};
      vt[5] = '{1'b0, 40'h1000, 1'b0, 1'b1, 1'b0, 40'h0,    1'b0, 1'b0, 1'b0, 1'b0, 40'h0,    1'b0, 1'b0, 1'b0};

      reset = 1'b1;
      hdr_i = {19'd0, 40'h1000}; hv_i = 1'b1; hd_i = 1'b0;
      d_i = '0; dv_i = 1'b0; last_i = 1'b0;
      hrdy_i = 1'b1; drdy_i = 1'b1; pend = '0;
      ew_v = 1'b1; ew_addr = 40'h2000; ew_byp = 1'b0; ew_up = 1'b0; ew_down = 1'b0; ew_clr = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset header_v_o", hv_o, 1'b0);
      chk("reset header_ready", hrdy_o, 1'b0);
      chk("reset data_ready", drdy_o, 1'b0);
      chk("reset pending_w_v_o", w_v_o, 1'b0);
      hv_i = 1'b0; ew_v = 1'b0; ew_addr = '0;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("empty after reset", empty_o, 1'b1);
      chk("idle header_v_o", hv_o, 1'b0);

      // Combinational decision table, applied between edges so no state changes
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         hv_i = vt[i].in_v; hdr_i = {19'h7, vt[i].addr}; pend = {4'b0000, vt[i].pend0};
         hrdy_i = vt[i].ordy; ew_v = vt[i].ew_v; ew_addr = vt[i].ew_addr; ew_down = vt[i].ew_down;
         #1;
         chk($sformatf("vec%0d", i), {hrdy_o, hv_o, w_v_o, w_addr_o, up_o, down_o, yumi_o},
             {vt[i].e_rdy, vt[i].e_outv, vt[i].e_wv, vt[i].e_waddr, vt[i].e_up, vt[i].e_down, vt[i].e_yumi});
         hv_i = 1'b0; ew_v = 1'b0; ew_addr = '0; ew_down = 1'b0; hrdy_i = 1'b1; pend = '0;
      end

      // Blocked 4-beat request parks in queue 2, then drains with its data
      set_pend('1);
      send_req(40'h1080, 19'd1, 4);
      @(negedge clk);
      chk("empty with parked req", empty_o, 1'b0);
      chk("queue2 head lookup addr", r_addr[3*PA +: PA], 40'h1080);
      exp_req(40'h1080, 19'd1, 4);
      set_pend('0);
      drain();
      chk("empty after q2 drain", empty_o, 1'b1);

      // Round-robin between queues 0 and 2
      set_pend('1);
      send_req(40'h2000, 19'd2, 0);
      send_req(40'h2080, 19'd3, 0);
      send_req(40'h2100, 19'd4, 0);
      send_req(40'h2180, 19'd5, 0);
      exp_req(40'h2000, 19'd2, 0);
      exp_req(40'h2080, 19'd3, 0);
      exp_req(40'h2100, 19'd4, 0);
      exp_req(40'h2180, 19'd5, 0);
      set_pend('0);
      drain();
      chk("empty after round-robin", empty_o, 1'b1);

      // Unblocked request to a line whose queue is occupied must queue behind
      set_pend('1);
      send_req(40'h3040, 19'd6, 0);
      set_pend(5'b11110);
      send_req(40'h3140, 19'd7, 0);
      @(negedge clk);
      chk("queue1 head still older req", r_addr[2*PA +: PA], 40'h3040);
      exp_req(40'h3040, 19'd6, 0);
      exp_req(40'h3140, 19'd7, 0);
      set_pend('0);
      drain();

      // Full blocked queue 0 stalls the input while queue 3 still sends
      set_pend('1);
      send_req(40'h4000, 19'd8, 0);
      send_req(40'h4100, 19'd9, 0);
      send_req(40'h40C0, 19'd10, 0);
      exp_req(40'h40C0, 19'd10, 0);
      @(posedge clk); #1;
      pend = 5'b01111;
      hdr_i = {19'd11, 40'h4200}; hd_i = 1'b0; hv_i = 1'b1;
      @(negedge clk);
      chk("stall while q3 sends", {hrdy_o, hv_o}, 2'b01);
      drain();
      @(negedge clk);
      chk("stall on full queue", hrdy_o, 1'b0);
      @(posedge clk); #1;
      hv_i = 1'b0;
      exp_req(40'h4000, 19'd8, 0);
      exp_req(40'h4100, 19'd9, 0);
      pend = '0;
      drain();
      chk("empty after stall test", empty_o, 1'b1);

`ifdef BP_CCE_HYBRID_PENDING_FAIRNESS_EN
      // Streak limit 2: new unblocked request takes the third grant
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      set_pend('1);
      send_req(40'h2000, 19'd12, 0);
      send_req(40'h2100, 19'd13, 0);
      send_req(40'h2080, 19'd14, 0);
      send_req(40'h2180, 19'd15, 0);
      exp_req(40'h2000, 19'd12, 0);
      exp_req(40'h2080, 19'd14, 0);
      exp_req(40'h5040, 19'd16, 0);
      exp_req(40'h2100, 19'd13, 0);
      exp_req(40'h2180, 19'd15, 0);
      @(posedge clk); #1;
      pend = '0;
      hdr_i = {19'd16, 40'h5040}; hd_i = 1'b0; hv_i = 1'b1;
      wait_in(1'b0);
      hv_i = 1'b0;
      drain();
      chk("empty after fairness", empty_o, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/bp_cce_hybrid_pending_multi.md
# bp_cce_hybrid_pending_multi

Multi-queue successor of the hybrid CCE pending stage. It sits between the LCE request input and the CCE request pipeline. Each new request looks up the pending bits; blocked requests park in one of `num_queues_p` pending queues selected by block-address bits. Unblocked queues drain in round-robin order, so one hot blocked line no longer stalls requests to unrelated lines.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `lce_id_width_p`, `cce_id_width_p`, `lce_assoc_p`, `cce_block_width_p`.
- `lce_data_width_p`, `dword_width_gp`: width of one data beat.
- `num_queues_p`, 4: number of pending queues; power of 2, ≥1.
- `header_els_p`, 2: header depth per queue.
- `data_els_p`, 2: data-beat depth per queue.
- `max_streak_p`, 4: fairness limit; used only when the configuration macro is defined.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `lce_req_header_i`/`_v_i`/`_ready_and_o`, `lce_req_has_data_i`, `lce_req_data_i`/`_v_i`/`_ready_and_o`, `lce_req_last_i`: new LCE request, BedRock burst ready&valid, header width `lce_req_msg_header_width_lp`.
- `lce_req_header_o`/`_v_o`/`_ready_and_i`, `lce_req_has_data_o`, `lce_req_data_o`/`_v_o`/`_ready_and_i`, `lce_req_last_o`: request out to the CCE pipeline, same protocol.
- `pending_r_addr_o`  out  (`num_queues_p`+1)×`paddr_width_p`: lookup addresses. Slot 0 is the new input; slot q+1 is the head of queue q.
- `pending_r_i`  in  `num_queues_p`+1: combinational pending bits returned for each lookup slot.
- `pending_w_v_i`, `pending_w_yumi_o`, `pending_w_addr_i`, `pending_w_addr_bypass_hash_i`, `pending_up_i`, `pending_down_i`, `pending_clear_i`: external pending write request.
- `pending_w_v_o`, `pending_w_addr_o`, `pending_w_addr_bypass_hash_o`, `pending_up_o`, `pending_down_o`, `pending_clear_o`  out: merged write to the pending-bit table.
- `empty_o`  out  1: all queues hold no headers and no data.

## Operation
- Queue index: `addr[lg_block_bytes +: lg(num_queues_p)]`. It is 0 when `num_queues_p`=1.
- A new request is blocked if `pending_r_i[0]`=1, or if its target queue is non-empty. The second condition preserves per-line order.
- In `e_ready`, sources are evaluated in priority order:
  1. Unblocked queue heads (head valid and `pending_r_i[q+1]`=0). A round-robin pointer picks one. The pointer advances past the granted queue on the header handshake.
  2. The new request, if unblocked.
  3. The new request, if blocked. It is enqueued to its target queue only when that queue's header FIFO is ready. Otherwise `lce_req_header_ready_and_o`=0.
- Header sent to output with handshake: drive the pending write with up=1, down=0, clear=0, bypass=0 and the header address. Assert `pending_w_yumi_o`=0 that cycle, so the external write stalls.
- All other cycles: the external write passes through and `pending_w_yumi_o` = `pending_w_v_i`.
- `has_data` header sent out: go to `e_data_to_out`. The registered source id (queue idx or new input) steers the beats. Return to `e_ready` after the `last` beat handshakes.
- `has_data` header enqueued: go to `e_data_to_pending`. The registered target queue receives beats until the `last` handshake, then return to `e_ready`.
- Headers are never accepted from any source while in a data state.
- Data paths use standard ready&valid. Queue outputs use yumi (valid & ready_and_i).

## Timing
- Header to output: combinational, 0 cycles, for both the bypass path and the queue-head path.
- Enqueued entry: visible at its queue head, and to lookup, the next cycle at the earliest.
- Pending bit raised by an output send: reflected in `pending_r_i` per the table's latency, which is 1 cycle. The block does not forward it itself.
- Reset values:
  - state = `e_ready`; round-robin pointer = 0; queues empty.
  - All `_v_o` = 0, all `_ready_and_o` = 0, `pending_w_v_o` = 0, `empty_o` = 1.
- Reset mid-burst drops partial data and all queue contents. Upstream is reset together with this block.
- Simultaneous events:
  - Queue head and new input both unblocked: the queue wins.
  - FSM pending write and external pending write in the same cycle: the FSM write wins.
- Full queue with a blocked new request targeting it: the input stalls. Unblocked queues and other sources still drain.

## Configuration
- `BP_CCE_HYBRID_PENDING_FAIRNESS_EN`:
  - Defined: a saturating counter tracks consecutive queue grants. When it reaches `max_streak_p` and an unblocked new request is waiting, the new request takes priority for one grant. The counter clears on any new-input grant.
  - Undefined: queues always have strict priority and the counter is not built.

## Test plan
- Single unblocked request A=0x1000, no data → out the same cycle; pending write up@0x1000; `pending_w_yumi_o`=0 that cycle.
- Request with 4 beats while `pending_r_i[0]`=1 → header plus 4 beats land in queue `addr[6+:2]`; output idle; `empty_o`=0.
- Queues 0 and 2 both loaded, bits clear → send order q0, q2, q0, q2 (round-robin); `empty_o`=1 after the last one.
- Queue 1 non-empty, new request to the queue-1 line with its bit clear → request is enqueued behind the existing entry, not bypassed.
- Target queue full and blocked, new request arrives → `lce_req_header_ready_and_o`=0, and an unblocked queue-3 head still sends.
- FAIRNESS_EN, `max_streak_p`=2, continuous queue traffic plus an unblocked new request → new request sent on the 3rd grant.
